// File: rtl/dmi_pkg.sv
// Shared types and DMI op status codes for the core-side DMI request controller.
package dmi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam logic [1:0] DMI_OP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_OP_FAILED  = 2'd2;
  localparam logic [1:0] DMI_OP_BUSY    = 2'd3;

endpackage

// File: rtl/dmi_req_ctrl.sv
// Converts synchronized DMI request pulses into valid/ready debug-module transactions,
// tracks the response, and keeps the sticky dmistat status reported to the TAP.
module dmi_req_ctrl
  import dmi_pkg::*;
#(
  parameter int          AWIDTH    = 7,
  parameter int          TIMEOUT   = 255,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              req_en,
  input  logic              req_wr,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              dmi_reset,
  input  logic              dmi_hard_reset,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic              dm_req_wr,
  output logic [AWIDTH-1:0] dm_req_addr,
  output logic [31:0]       dm_req_wdata,
  input  logic              dm_resp_valid,
  input  logic              dm_resp_err,
  input  logic [31:0]       dm_resp_rdata,
  output logic [31:0]       rd_data,
  output logic [1:0]        rd_status,
  output logic [1:0]        dmi_stat,
  output logic [2:0]        idle,
  output logic              busy
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [1:0]          status_reg, status_next, status_base;
  logic [7:0]          cnt_reg, cnt_next;
  logic [31:0]         rd_data_reg, rd_data_next;
  logic                wr_reg, wr_next;
  logic [AWIDTH-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_reg   <= IDLE;
      status_reg  <= DMI_OP_SUCCESS;
      cnt_reg     <= 8'd0;
      rd_data_reg <= 32'd0;
      wr_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= 32'd0;
    end else begin
      state_reg   <= state_next;
      status_reg  <= status_next;
      cnt_reg     <= cnt_next;
      rd_data_reg <= rd_data_next;
      wr_reg      <= wr_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rd_data_next = rd_data_reg;
    wr_next      = wr_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    // dmi_reset clears first so a same-cycle request or completion sees a clean status
    status_base  = dmi_reset ? DMI_OP_SUCCESS : status_reg;
    status_next  = status_base;

    unique case (state_reg)
      IDLE: begin
        if (req_en && status_base == DMI_OP_SUCCESS) begin
          wr_next    = req_wr;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          state_next = REQ;
        end
      end
      REQ: begin
        if (req_en && status_base == DMI_OP_SUCCESS) status_next = DMI_OP_BUSY;
        if (dm_req_ready) begin
          state_next = WAIT_RSP;
          cnt_next   = 8'd0;
        end
      end
      WAIT_RSP: begin
        cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
        if (dm_resp_valid) begin
          if (!wr_reg && !dm_resp_err) rd_data_next = dm_resp_rdata;
          if (status_base == DMI_OP_SUCCESS)
            status_next = dm_resp_err ? DMI_OP_FAILED : DMI_OP_SUCCESS;
          state_next = IDLE;
        end else if (cnt_reg == TMO_LAST) begin
          if (status_base == DMI_OP_SUCCESS) status_next = DMI_OP_FAILED;
          state_next = IDLE;
        end
        // a colliding request marks busy even if this op completes now
        if (req_en && status_base == DMI_OP_SUCCESS) status_next = DMI_OP_BUSY;
      end
      default: state_next = IDLE;
    endcase

    if (dmi_hard_reset) begin
      state_next   = IDLE;
      cnt_next     = 8'd0;
      status_next  = DMI_OP_SUCCESS;
      rd_data_next = rd_data_reg;
      wr_next      = wr_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
    end
  end

  assign dm_req_valid = (state_reg == REQ);
  assign dm_req_wr    = wr_reg;
  assign dm_req_addr  = addr_reg;
  assign dm_req_wdata = wdata_reg;
  assign rd_data      = rd_data_reg;
  assign rd_status    = status_reg;
  assign dmi_stat     = status_reg;
  assign idle         = IDLE_HINT;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_dmi_req_ctrl.sv
// Self-checking bench for dmi_req_ctrl: directed scenarios plus randomized ops
// checked against a transaction-level model of the status/read-data rules.
module tb_dmi_req_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_l, req_en, req_wr, dmi_reset, dmi_hard_reset;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        dm_req_valid, dm_req_ready, dm_req_wr;
  logic [6:0]  dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic        dm_resp_valid, dm_resp_err;
  logic [31:0] dm_resp_rdata, rd_data;
  logic [1:0]  rd_status, dmi_stat;
  logic [2:0]  idle;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd;
  logic [1:0]  exp_st;

  dmi_req_ctrl #(.AWIDTH(7), .TIMEOUT(TMO), .IDLE_HINT(3'd1)) dut (
    .clk(clk), .rst_l(rst_l), .req_en(req_en), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .dmi_reset(dmi_reset),
    .dmi_hard_reset(dmi_hard_reset), .dm_req_valid(dm_req_valid),
    .dm_req_ready(dm_req_ready), .dm_req_wr(dm_req_wr), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_resp_valid(dm_resp_valid),
    .dm_resp_err(dm_resp_err), .dm_resp_rdata(dm_resp_rdata), .rd_data(rd_data),
    .rd_status(rd_status), .dmi_stat(dmi_stat), .idle(idle), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [6:0] a, input logic [31:0] d);
    req_wr = wr; req_addr = a; req_wdata = d; req_en = 1'b1;
    step();
    req_en = 1'b0;
  endtask

  // Holds ready low for 'dly' cycles checking valid stays up, then completes the handshake.
  task automatic handshake(input int dly);
    for (int i = 0; i < dly; i++) begin
      step();
      checks++;
      if (dm_req_valid !== 1'b1) begin
        errors++; $display("FAIL hold_valid: got %b want 1", dm_req_valid);
      end
    end
    dm_req_ready = 1'b1;
    step();
    dm_req_ready = 1'b0;
    checks++;
    if (dm_req_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL post_handshake: valid=%b busy=%b want 0/1", dm_req_valid, busy);
    end
  endtask

  task automatic pulse_resp(input logic err, input logic [31:0] d);
    dm_resp_valid = 1'b1; dm_resp_err = err; dm_resp_rdata = d;
    step();
    dm_resp_valid = 1'b0; dm_resp_err = 1'b0;
  endtask

  task automatic pulse_dmi_reset();
    dmi_reset = 1'b1;
    step();
    dmi_reset = 1'b0;
    exp_st = 2'd0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    step(); step();
    rst_l = 1'b1;
    checks++;
    if (dm_req_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 32'd0 || rd_status !== 2'd0 ||
        dm_req_wr !== 1'b0 || dm_req_addr !== 7'd0 || dm_req_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b rd=%h st=%0d wr=%b addr=%h wd=%h want all 0",
               dm_req_valid, busy, rd_data, rd_status, dm_req_wr, dm_req_addr, dm_req_wdata);
    end
    checks++;
    if (idle !== 3'd1) begin errors++; $display("FAIL reset_idle: got %0d want 1", idle); end
    exp_rd = 32'd0; exp_st = 2'd0;
    $display("reset done");
  endtask

  task automatic test_read();
    issue(1'b0, 7'h11, 32'h0);
    checks++;
    if (dm_req_valid !== 1'b1 || dm_req_addr !== 7'h11 || dm_req_wr !== 1'b0) begin
      errors++; $display("FAIL read_issue: valid=%b addr=%h wr=%b want 1/11/0", dm_req_valid, dm_req_addr, dm_req_wr);
    end
    handshake(2);
    step(); step();
    pulse_resp(1'b0, 32'hDEADBEEF);
    exp_rd = 32'hDEADBEEF;
    checks++;
    if (rd_data !== exp_rd || rd_status !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL read_done: rd=%h st=%0d busy=%b want deadbeef/0/0", rd_data, rd_status, busy);
    end
    $display("read addr=11 rd_data=%h status=%0d", rd_data, rd_status);
  endtask

  task automatic test_write();
    issue(1'b1, 7'h10, 32'h1);
    checks++;
    if (dm_req_wr !== 1'b1 || dm_req_wdata !== 32'h1 || dm_req_addr !== 7'h10) begin
      errors++; $display("FAIL write_fields: wr=%b wd=%h addr=%h want 1/1/10", dm_req_wr, dm_req_wdata, dm_req_addr);
    end
    handshake(0);
    pulse_resp(1'b1, 32'h55AA55AA);
    exp_st = 2'd2;
    checks++;
    if (rd_data !== exp_rd || rd_status !== 2'd2 || dmi_stat !== 2'd2) begin
      errors++; $display("FAIL write_err: rd=%h st=%0d stat=%0d want %h/2/2", rd_data, rd_status, dmi_stat, exp_rd);
    end
    step(); step();
    issue(1'b0, 7'h22, 32'h0);
    checks++;
    if (dm_req_valid !== 1'b0 || busy !== 1'b0 || rd_status !== 2'd2) begin
      errors++; $display("FAIL sticky_drop: valid=%b busy=%b st=%0d want 0/0/2", dm_req_valid, busy, rd_status);
    end
    $display("write addr=10 status=%0d (next op dropped)", rd_status);
    pulse_dmi_reset();
  endtask

  task automatic test_busy();
    issue(1'b0, 7'h05, 32'h0);
    handshake(1);
    issue(1'b1, 7'h06, 32'h9);
    checks++;
    if (rd_status !== 2'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL busy_set: st=%0d busy=%b want 3/1", rd_status, busy);
    end
    pulse_resp(1'b0, 32'h12345678);
    exp_rd = 32'h12345678;
    checks++;
    if (rd_status !== 2'd3 || rd_data !== exp_rd || busy !== 1'b0) begin
      errors++; $display("FAIL busy_keep: st=%0d rd=%h busy=%b want 3/12345678/0", rd_status, rd_data, busy);
    end
    pulse_dmi_reset();
    checks++;
    if (rd_status !== 2'd0) begin errors++; $display("FAIL busy_clear: st=%0d want 0", rd_status); end
    issue(1'b0, 7'h07, 32'h0);
    checks++;
    if (dm_req_valid !== 1'b1) begin errors++; $display("FAIL busy_reissue: valid=%b want 1", dm_req_valid); end
    handshake(0);
    pulse_resp(1'b0, 32'hCAFE0001);
    exp_rd = 32'hCAFE0001;
    $display("busy scenario rd_data=%h status=%0d", rd_data, rd_status);
  endtask

  task automatic test_timeout();
    issue(1'b0, 7'h33, 32'h0);
    handshake(0);
    for (int i = 0; i < TMO - 1; i++) begin
      step();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL tmo_early: cycle %0d busy=%b want 1", i, busy); end
    end
    step();
    checks++;
    if (busy !== 1'b0 || rd_status !== 2'd2 || rd_data !== exp_rd) begin
      errors++; $display("FAIL tmo_end: busy=%b st=%0d rd=%h want 0/2/%h", busy, rd_status, rd_data, exp_rd);
    end
    pulse_resp(1'b0, 32'hBAD0BAD0);
    checks++;
    if (rd_data !== exp_rd || rd_status !== 2'd2) begin
      errors++; $display("FAIL tmo_late: rd=%h st=%0d want %h/2", rd_data, rd_status, exp_rd);
    end
    $display("timeout status=%0d", rd_status);
    pulse_dmi_reset();
  endtask

  task automatic test_hard_reset();
    issue(1'b0, 7'h44, 32'h0);
    step();
    dmi_hard_reset = 1'b1;
    step();
    dmi_hard_reset = 1'b0;
    checks++;
    if (dm_req_valid !== 1'b0 || busy !== 1'b0 || rd_status !== 2'd0) begin
      errors++; $display("FAIL hard_abort: valid=%b busy=%b st=%0d want 0/0/0", dm_req_valid, busy, rd_status);
    end
    pulse_resp(1'b1, 32'h0BADF00D);
    checks++;
    if (rd_data !== exp_rd || rd_status !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL hard_late: rd=%h st=%0d busy=%b want %h/0/0", rd_data, rd_status, busy, exp_rd);
    end
    $display("hard reset status=%0d", rd_status);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic        wr, err, inj, tmo;
      logic [6:0]  a;
      logic [31:0] d, rdat;
      int          rdy, dly;
      if (exp_st != 2'd0 && $urandom_range(0, 2) != 0) pulse_dmi_reset();
      wr = 1'($urandom); a = 7'($urandom); d = $urandom; rdat = $urandom;
      err = ($urandom_range(0, 3) == 0); tmo = ($urandom_range(0, 4) == 0);
      inj = ($urandom_range(0, 3) == 0);
      rdy = $urandom_range(0, 3); dly = $urandom_range(1, TMO - 1);
      issue(wr, a, d);
      if (exp_st != 2'd0) begin
        checks++;
        if (dm_req_valid !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL rnd_drop %0d: valid=%b busy=%b want 0/0", n, dm_req_valid, busy);
        end
        $display("op %0d dropped (status %0d)", n, exp_st);
        continue;
      end
      checks++;
      if (dm_req_valid !== 1'b1 || dm_req_wr !== wr || dm_req_addr !== a || dm_req_wdata !== d) begin
        errors++; $display("FAIL rnd_req %0d: v=%b wr=%b a=%h d=%h want 1/%b/%h/%h",
                           n, dm_req_valid, dm_req_wr, dm_req_addr, dm_req_wdata, wr, a, d);
      end
      handshake(rdy);
      // waiting phase: optional colliding request in the first cycle, then response or timeout
      for (int c = 0; c < TMO; c++) begin
        req_en = inj && (c == 0);
        req_wr = 1'b0;
        if (req_en && exp_st == 2'd0) exp_st = 2'd3;
        if (!tmo && c == dly) begin
          dm_resp_valid = 1'b1; dm_resp_err = err; dm_resp_rdata = rdat;
        end
        step();
        req_en = 1'b0; dm_resp_valid = 1'b0; dm_resp_err = 1'b0;
        if (!tmo && c == dly) break;
      end
      if (tmo) begin
        if (exp_st == 2'd0) exp_st = 2'd2;
      end else begin
        if (!wr && !err) exp_rd = rdat;
        if (exp_st == 2'd0) exp_st = err ? 2'd2 : 2'd0;
      end
      checks++;
      if (rd_data !== exp_rd || rd_status !== exp_st || dmi_stat !== exp_st || busy !== 1'b0) begin
        errors++; $display("FAIL rnd_done %0d: rd=%h st=%0d stat=%0d busy=%b want %h/%0d/%0d/0",
                           n, rd_data, rd_status, dmi_stat, busy, exp_rd, exp_st, exp_st);
      end
      $display("op %0d wr=%b addr=%h tmo=%b err=%b inj=%b rd_data=%h status=%0d",
               n, wr, a, tmo, err, inj, rd_data, rd_status);
    end
  endtask

  task automatic test_reset_mid_wait();
    pulse_dmi_reset();
    issue(1'b1, 7'h7F, 32'hFFFF0000);
    handshake(0);
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    checks++;
    if (dm_req_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 32'd0 || rd_status !== 2'd0 ||
        dm_req_wr !== 1'b0 || dm_req_addr !== 7'd0 || dm_req_wdata !== 32'd0 || idle !== 3'd1) begin
      errors++;
      $display("FAIL reset_mid_wait: valid=%b busy=%b rd=%h st=%0d wr=%b addr=%h wd=%h idle=%0d want 0s/idle 1",
               dm_req_valid, busy, rd_data, rd_status, dm_req_wr, dm_req_addr, dm_req_wdata, idle);
    end
    $display("reset mid wait done");
  endtask

  initial begin
    rst_l = 1'b0; req_en = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    dmi_reset = 1'b0; dmi_hard_reset = 1'b0; dm_req_ready = 1'b0;
    dm_resp_valid = 1'b0; dm_resp_err = 1'b0; dm_resp_rdata = '0;
    test_reset();
    test_read();
    test_write();
    test_busy();
    test_timeout();
    test_hard_reset();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
